// File: rtl/joypad_i2c_target.sv
// I2C target exposing a 16-bit joypad snapshot as two byte registers.
// Byte 0 of a write selects the register pointer; reads stream and wrap it.
module joypad_i2c_target #(
    parameter logic [6:0] ADDR = 7'h52
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_out,
    input  logic [15:0] buttons,
    output logic        busy,
    output logic        rd_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_WAIT
    } state_t;

    logic scl_m_q, scl_s_q, scl_p_q;
    logic sda_m_q, sda_s_q, sda_p_q;

    // Two-flop synchronizers plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_m_q <= 1'b1;
            scl_s_q <= 1'b1;
            scl_p_q <= 1'b1;
            sda_m_q <= 1'b1;
            sda_s_q <= 1'b1;
            sda_p_q <= 1'b1;
        end else begin
            scl_m_q <= scl_in;
            scl_s_q <= scl_m_q;
            scl_p_q <= scl_s_q;
            sda_m_q <= sda_in;
            sda_s_q <= sda_m_q;
            sda_p_q <= sda_s_q;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise  = scl_s_q & ~scl_p_q;
    assign scl_fall  = ~scl_s_q & scl_p_q;
    assign start_det = scl_s_q & scl_p_q & sda_p_q & ~sda_s_q;
    assign stop_det  = scl_s_q & scl_p_q & ~sda_p_q & sda_s_q;

    state_t      state_q;
    logic [2:0]  bcnt_q;
    logic        full_q;
    logic [7:0]  shreg_q;
    logic        first_q;
    logic        ptr_q;
    logic [15:0] snap_q;
    logic        sda_q;
    logic        busy_q;
    logic        done_q;

    logic [7:0] rd_byte_d;
    logic [7:0] btn_byte_d;

    assign rd_byte_d  = ptr_q ? snap_q[15:8] : snap_q[7:0];
    assign btn_byte_d = ptr_q ? buttons[15:8] : buttons[7:0];

    // Protocol FSM; START/STOP override any in-progress byte
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            bcnt_q  <= 3'd0;
            full_q  <= 1'b0;
            shreg_q <= 8'h00;
            first_q <= 1'b0;
            ptr_q   <= 1'b0;
            snap_q  <= 16'h0000;
            sda_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_det) begin
                state_q <= S_ADDR;
                bcnt_q  <= 3'd0;
                full_q  <= 1'b0;
                sda_q   <= 1'b1;
                busy_q  <= 1'b0;
            end else if (stop_det) begin
                state_q <= S_IDLE;
                bcnt_q  <= 3'd0;
                full_q  <= 1'b0;
                sda_q   <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    S_ADDR, S_WR_DATA: begin
                        if (scl_rise) begin
                            shreg_q <= {shreg_q[6:0], sda_s_q};
                            bcnt_q  <= bcnt_q + 3'd1;
                            if (bcnt_q == 3'd7) full_q <= 1'b1;
                        end else if (scl_fall && full_q) begin
                            full_q <= 1'b0;
                            if (state_q == S_WR_DATA) begin
                                state_q <= S_WR_ACK;
                                sda_q   <= 1'b0;
                                if (first_q) begin
                                    ptr_q   <= shreg_q[0];
                                    first_q <= 1'b0;
                                end
                            end else if (shreg_q[7:1] == ADDR) begin
                                state_q <= S_ADDR_ACK;
                                sda_q   <= 1'b0;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= S_WAIT;
                                sda_q   <= 1'b1;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            bcnt_q <= 3'd0;
                            if (shreg_q[0]) begin
                                state_q <= S_RD_DATA;
                                snap_q  <= buttons;
                                sda_q   <= btn_byte_d[7];
                            end else begin
                                state_q <= S_WR_DATA;
                                sda_q   <= 1'b1;
                                first_q <= 1'b1;
                            end
                        end
                    end
                    S_WR_ACK: begin
                        if (scl_fall) begin
                            state_q <= S_WR_DATA;
                            sda_q   <= 1'b1;
                            bcnt_q  <= 3'd0;
                        end
                    end
                    S_RD_DATA: begin
                        if (scl_rise) begin
                            bcnt_q <= bcnt_q + 3'd1;
                            if (bcnt_q == 3'd7) full_q <= 1'b1;
                        end else if (scl_fall) begin
                            if (full_q) begin
                                full_q  <= 1'b0;
                                sda_q   <= 1'b1;
                                state_q <= S_RD_ACK;
                            end else begin
                                sda_q <= rd_byte_d[3'd7 - bcnt_q];
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s_q) begin
                                ptr_q   <= ~ptr_q;
                                state_q <= S_RD_DATA;
                                bcnt_q  <= 3'd0;
                            end else begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_WAIT;
                            end
                        end
                    end
                    S_IDLE, S_WAIT: begin
                        sda_q <= 1'b1;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        sda_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign sda_out = sda_q;
    assign busy    = busy_q;
    assign rd_done = done_q;

endmodule

// File: tb/tb_joypad_i2c_target.sv
// Bench for joypad_i2c_target: bus-level master plus a frame scoreboard.
// Each 9-bit frame seen on the bus is popped against the expected queue.
`timescale 1ns/1ps
module tb_joypad_i2c_target;

    localparam int Q = 100;

    logic        clk;
    logic        rst;
    logic        m_scl;
    logic        m_sda;
    logic        sda_out;
    logic [15:0] buttons;
    logic        busy;
    logic        rd_done;
    logic        sda_bus;

    assign sda_bus = m_sda & sda_out;

    joypad_i2c_target #(.ADDR(7'h52)) dut (
        .clk     (clk),
        .rst     (rst),
        .scl_in  (m_scl),
        .sda_in  (sda_bus),
        .sda_out (sda_out),
        .buttons (buttons),
        .busy    (busy),
        .rd_done (rd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    int rd_cnt = 0;
    int low_cnt = 0;
    int busy_cnt = 0;

    always @(posedge clk) begin
        if (rd_done) rd_cnt <= rd_cnt + 1;
        if (!sda_out) low_cnt <= low_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input logic a);
        exp_q.push_back({b, a});
    endtask

    // Bus monitor: frames bits on SCL rise, resyncs on START/STOP
    initial begin
        int nb;
        logic [8:0] sh;
        logic scl_p;
        logic sda_p;
        logic [8:0] e;
        nb = 0;
        sh = '0;
        scl_p = 1'b1;
        sda_p = 1'b1;
        forever begin
            @(m_scl or sda_bus);
            if (m_scl && !scl_p) begin
                sh = {sh[7:0], sda_bus};
                nb++;
                if (nb == 9) begin
                    nb = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame unexpected got %h", sh);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame", {7'd0, sh}, {7'd0, e});
                    end
                end
            end else if (m_scl && scl_p && sda_bus != sda_p) begin
                nb = 0;
            end
            scl_p = m_scl;
            sda_p = sda_bus;
        end
    end

    task automatic i2c_start();
        m_sda = 1'b1;
        #Q m_scl = 1'b1;
        #Q m_sda = 1'b0;
        #Q m_scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        #Q m_scl = 1'b1;
        #Q m_sda = 1'b1;
        #Q;
    endtask

    task automatic i2c_bit(input logic b);
        m_sda = b;
        #Q m_scl = 1'b1;
        #(2*Q) m_scl = 1'b0;
        #Q;
    endtask

    task automatic frame(input logic [7:0] mb, input logic ack);
        for (int i = 7; i >= 0; i--) i2c_bit(mb[i]);
        i2c_bit(ack);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo0;
        int bz0;
        rst = 1'b1;
        m_scl = 1'b1;
        m_sda = 1'b1;
        buttons = 16'h0000;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_sda", {15'd0, sda_out}, 16'd1);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, rd_done}, 16'd0);

        // Two-byte read, ACK then NACK
        buttons = 16'h3C81;
        i2c_start();
        push(8'hA5, 1'b0);
        frame(8'hA5, 1'b1);
        chk("busy_rd", {15'd0, busy}, 16'd1);
        push(8'h81, 1'b0);
        frame(8'hFF, 1'b0);
        push(8'h3C, 1'b1);
        frame(8'hFF, 1'b1);
        i2c_stop();
        repeat (5) @(negedge clk);
        chk("rd_done_1", rd_cnt[15:0], 16'd1);
        chk("busy_stop1", {15'd0, busy}, 16'd0);

        // Write pointer 1, then one-byte read
        buttons = 16'h5A00;
        i2c_start();
        push(8'hA4, 1'b0);
        frame(8'hA4, 1'b1);
        push(8'h01, 1'b0);
        frame(8'h01, 1'b1);
        chk("busy_wr", {15'd0, busy}, 16'd1);
        i2c_stop();
        repeat (5) @(negedge clk);
        chk("busy_stop2", {15'd0, busy}, 16'd0);
        i2c_start();
        push(8'hA5, 1'b0);
        frame(8'hA5, 1'b1);
        push(8'h5A, 1'b1);
        frame(8'hFF, 1'b1);
        i2c_stop();

        // Foreign address: never pulls SDA, never busy
        lo0 = low_cnt;
        bz0 = busy_cnt;
        i2c_start();
        push(8'hA7, 1'b1);
        frame(8'hA7, 1'b1);
        push(8'hFF, 1'b1);
        frame(8'hFF, 1'b1);
        i2c_stop();
        repeat (5) @(negedge clk);
        chk("nomatch_low", 16'(low_cnt - lo0), 16'd0);
        chk("nomatch_busy", 16'(busy_cnt - bz0), 16'd0);

        // Pointer wrap over three bytes
        i2c_start();
        push(8'hA4, 1'b0);
        frame(8'hA4, 1'b1);
        push(8'h00, 1'b0);
        frame(8'h00, 1'b1);
        i2c_stop();
        buttons = 16'h1234;
        i2c_start();
        push(8'hA5, 1'b0);
        frame(8'hA5, 1'b1);
        push(8'h34, 1'b0);
        frame(8'hFF, 1'b0);
        push(8'h12, 1'b0);
        frame(8'hFF, 1'b0);
        push(8'h34, 1'b1);
        frame(8'hFF, 1'b1);
        i2c_stop();

        // Buttons change mid-byte; snapshot must hold
        buttons = 16'h0001;
        i2c_start();
        push(8'hA5, 1'b0);
        frame(8'hA5, 1'b1);
        push(8'h01, 1'b1);
        fork
            frame(8'hFF, 1'b1);
            begin
                #(16*Q);
                buttons = 16'h0002;
            end
        join
        i2c_stop();

        // Repeated START after read address ACK, then a write
        buttons = 16'hFFFF;
        i2c_start();
        push(8'hA5, 1'b0);
        frame(8'hA5, 1'b1);
        chk("busy_rs_pre", {15'd0, busy}, 16'd1);
        i2c_start();
        chk("busy_rs_post", {15'd0, busy}, 16'd0);
        push(8'hA4, 1'b0);
        frame(8'hA4, 1'b1);
        push(8'h01, 1'b0);
        frame(8'h01, 1'b1);
        i2c_stop();

        // Reset mid-byte while the target drives SDA low
        buttons = 16'h0000;
        i2c_start();
        push(8'hA5, 1'b0);
        frame(8'hA5, 1'b1);
        i2c_bit(1'b1);
        i2c_bit(1'b1);
        i2c_bit(1'b1);
        chk("pre_rst_sda", {15'd0, sda_out}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_sda", {15'd0, sda_out}, 16'd1);
        chk("rst_mid_busy", {15'd0, busy}, 16'd0);
        rst = 1'b0;
        i2c_stop();

        // Recovery: pointer back to 0 after reset
        buttons = 16'h00C3;
        i2c_start();
        push(8'hA5, 1'b0);
        frame(8'hA5, 1'b1);
        push(8'hC3, 1'b1);
        frame(8'hFF, 1'b1);
        i2c_stop();
        repeat (10) @(negedge clk);
        chk("rd_done_total", rd_cnt[15:0], 16'd5);
        chk("busy_end", {15'd0, busy}, 16'd0);
        chk("queue_empty", 16'(exp_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/joypad_i2c_target.md
JOYPAD_I2C_TARGET -- requirements
Module: joypad_i2c_target

Interface
REQ-001 SHALL have parameter ADDR, default 7'h52, the 7-bit target address it responds to.
REQ-002 SHALL have port clk, input, 1, the single clock for all logic (≥10x SCL frequency).
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port scl_in, input, 1, raw bus SCL level (asynchronous).
REQ-005 SHALL have port sda_in, input, 1, raw bus SDA level (asynchronous).
REQ-006 SHALL have port sda_out, output, 1, open-drain control: 0 = pull SDA low, 1 = release.
REQ-007 SHALL have port buttons, input, 16, live button state; reg0 = buttons[7:0], reg1 = buttons[15:8].
REQ-008 SHALL have port busy, output, 1, high from an address-matched ACK until STOP, repeated START, or NACK-abort.
REQ-009 SHALL have port rd_done, output, 1, one-cycle pulse when the master NACKs a read byte.

Function
REQ-010 SHALL pass scl_in and sda_in through 2-flop synchronizers; all detection uses the synchronized values plus one delayed copy.
REQ-011 SHALL detect START as synchronized SDA 1->0 while SCL high, and STOP as SDA 0->1 while SCL high; both are legal in any state.
REQ-012 SHALL sample SDA on the clk cycle where a synchronized SCL rising edge is detected, MSB first.
REQ-013 SHALL change sda_out only on the clk cycle after a synchronized SCL falling edge is detected.
REQ-014 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT.
REQ-015 SHALL enter ADDR on START from any state and clear the bit counter (3 bits).
REQ-016 In ADDR, after 8 bits: if bits[7:1] == ADDR, SHALL go to ADDR_ACK; otherwise SHALL go to WAIT with sda_out = 1.
REQ-017 In ADDR_ACK, SHALL drive sda_out = 0 from the 8th SCL falling edge through the 9th SCL falling edge; at the 9th falling edge, R/W = 0 goes to WR_DATA and R/W = 1 goes to RD_DATA.
REQ-018 On the transition into a read, SHALL snapshot buttons into a 16-bit register; read data is taken only from the snapshot.
REQ-019 In WR_DATA, after 8 bits SHALL go to WR_ACK and ACK as in REQ-017; the first data byte after the address sets ptr = byte[0]; later bytes are ACKed and ignored.
REQ-020 In RD_DATA, SHALL drive snapshot byte ptr MSB first, one bit per SCL falling edge; the first bit is driven at the ADDR_ACK->RD_DATA edge.
REQ-021 After 8 read bits, SHALL release SDA (sda_out = 1), go to RD_ACK, and sample the master ACK on the 9th SCL rising edge.
REQ-022 In RD_ACK: ACK (0) SHALL toggle ptr and return to RD_DATA; NACK (1) SHALL pulse rd_done and go to WAIT.
REQ-023 ptr SHALL be 1 bit and wrap 1->0; it persists across transactions until reset or the next write.
REQ-024 In WAIT, SHALL keep sda_out = 1 until START (->ADDR) or STOP (->IDLE).
REQ-025 STOP in any state SHALL go to IDLE, set sda_out = 1, and clear busy on the next cycle.
REQ-026 If START and SCL falling-edge detection coincide, START SHALL take priority.
REQ-027 SHALL never drive SCL (no clock stretching).

Reset
REQ-028 On rst, SHALL set state = IDLE, sda_out = 1, busy = 0, rd_done = 0, ptr = 0, bit counter = 0, snapshot = 0, and synchronizer flops = 1.
REQ-029 rst asserted mid-transaction SHALL abort immediately with the REQ-028 values; the rest of that transaction is ignored until the next START.

Verification
REQ-030 Read 0xA5 (addr 0x52, R), buttons = 16'h3C81, master ACKs byte 1 and NACKs byte 2 -> address ACKed, bytes 0x81 then 0x3C, one rd_done pulse, busy low after STOP.
REQ-031 Write 0xA4 + 0x01, STOP, then read 1 byte with NACK, buttons = 16'h5A00 -> both write bytes ACKed, read returns 0x5A.
REQ-032 Address 0x53 read -> SDA never driven low during the transaction, busy stays 0, state WAIT until STOP.
REQ-033 Read of 3 bytes with ptr = 0 and buttons = 16'h1234 -> 0x34, 0x12, 0x34 (pointer wrap).
REQ-034 Buttons change from 16'h0001 to 16'h0002 in the middle of a read byte -> the transmitted byte is 0x01 (snapshot).
REQ-035 Repeated START after the read-address ACK, then a write to 0x52 -> write is accepted; rst pulsed mid-byte -> sda_out = 1 on the next clk.
